// File: rtl/multi_reaction_timer.sv
// multi_reaction_timer: N-player reaction timer with false-start, timeout, winner and best-time tracking
module multi_reaction_timer #(
   parameter int N_CH       = 2,
   parameter int TIME_W     = 16,
   parameter int TIMEOUT_MS = 9999,
   parameter int IDX_W      = 3
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     tick_1ms_i,
   input  logic                     arm_i,
   input  logic                     start_i,
   input  logic [N_CH-1:0]          stop_i,
   output logic [N_CH*TIME_W-1:0]   time_ms_o,
   output logic [N_CH-1:0]          done_o,
   output logic [N_CH-1:0]          false_start_o,
   output logic [N_CH-1:0]          timeout_o,
   output logic [IDX_W-1:0]         winner_o,
   output logic                     winner_valid_o,
   output logic [TIME_W-1:0]        best_ms_o,
   output logic                     best_valid_o,
   output logic                     busy_o
);
   typedef enum logic [1:0] {IDLE, ARMED, RUNNING, FINISHED} state_t;
   localparam logic [TIME_W-1:0] TMAX = TIME_W'(TIMEOUT_MS);
   state_t            state_q, state_d;
   logic [TIME_W-1:0] time_q [N_CH];
   logic [TIME_W-1:0] time_d [N_CH];
   logic [N_CH-1:0]   done_q, done_d, fs_q, fs_d, to_q, to_d, stop_v;
   logic [IDX_W-1:0]  win_q, win_d, first;
   logic [TIME_W-1:0] best_q, best_d, first_t;
   logic              wv_q, wv_d, bv_q, bv_d, busy_q;
   assign stop_v = stop_i & ~done_q;
   always_comb begin
      state_d = state_q;
      time_d  = time_q;
      done_d  = done_q;
      fs_d    = fs_q;
      to_d    = to_q;
      win_d   = win_q;
      wv_d    = wv_q;
      best_d  = best_q;
      bv_d    = bv_q;
      first   = '0;
      first_t = '0;
      for (int i = N_CH - 1; i >= 0; i--)
         if (stop_v[i]) begin
            first   = IDX_W'(i);
            first_t = time_q[i];
         end
      if (arm_i) begin
         state_d = ARMED;
         time_d  = '{default: '0};
         done_d  = '0;
         fs_d    = '0;
         to_d    = '0;
         win_d   = '0;
         wv_d    = 1'b0;
      end else if (state_q == ARMED) begin
         fs_d    = fs_q | stop_v;
         done_d  = done_q | stop_v;
         state_d = &done_d ? FINISHED : start_i ? RUNNING : ARMED;
      end else if (state_q == RUNNING) begin
         // a stop freezes the count even when a tick lands in the same cycle
         for (int i = 0; i < N_CH; i++)
            if (!done_q[i]) begin
               if (stop_i[i]) done_d[i] = 1'b1;
               else if (tick_1ms_i) begin
                  if (time_q[i] == TMAX) begin
                     to_d[i]   = 1'b1;
                     done_d[i] = 1'b1;
                  end else time_d[i] = time_q[i] + 1'b1;
               end
            end
         if (!wv_q && |stop_v) begin
            win_d = first;
            wv_d  = 1'b1;
            if (!bv_q || first_t < best_q) begin
               best_d = first_t;
               bv_d   = 1'b1;
            end
         end
         state_d = &done_d ? FINISHED : RUNNING;
      end
   end
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         state_q <= IDLE;
         time_q  <= '{default: '0};
         done_q  <= '0;
         fs_q    <= '0;
         to_q    <= '0;
         win_q   <= '0;
         wv_q    <= 1'b0;
         best_q  <= '0;
         bv_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         time_q  <= time_d;
         done_q  <= done_d;
         fs_q    <= fs_d;
         to_q    <= to_d;
         win_q   <= win_d;
         wv_q    <= wv_d;
         best_q  <= best_d;
         bv_q    <= bv_d;
         busy_q  <= (state_d == ARMED) || (state_d == RUNNING);
      end
   for (genvar i = 0; i < N_CH; i++) assign time_ms_o[i*TIME_W +: TIME_W] = time_q[i];
   assign done_o         = done_q;
   assign false_start_o  = fs_q;
   assign timeout_o      = to_q;
   assign winner_o       = win_q;
   assign winner_valid_o = wv_q;
   assign best_ms_o      = best_q;
   assign best_valid_o   = bv_q;
   assign busy_o         = busy_q;
endmodule

// File: tb/tb_multi_reaction_timer.sv
// tb_multi_reaction_timer: directed scenarios plus randomized rounds against a behavioural model
module tb_multi_reaction_timer;
   logic clk = 0, reset = 0, tk = 0, arm = 0, start = 0;
   logic [1:0] stop = '0;
   logic [31:0] t_a, t_b;
   logic [1:0] d_a, fs_a, to_a, d_b, fs_b, to_b;
   logic [2:0] w_a, w_b;
   logic [15:0] b_a, b_b;
   logic wv_a, bv_a, busy_a, wv_b, bv_b, busy_b;
   int total = 0, bad = 0;
   int m_phase;
   logic [15:0] m_t [2];
   logic [1:0] m_done, m_fs, m_to;
   logic [2:0] m_w;
   logic [15:0] m_best;
   logic m_wv, m_bv, m_busy;

   always #5 clk = ~clk;

   multi_reaction_timer dut_a (
      .clk_i(clk), .reset_i(reset), .tick_1ms_i(tk), .arm_i(arm), .start_i(start), .stop_i(stop),
      .time_ms_o(t_a), .done_o(d_a), .false_start_o(fs_a), .timeout_o(to_a), .winner_o(w_a),
      .winner_valid_o(wv_a), .best_ms_o(b_a), .best_valid_o(bv_a), .busy_o(busy_a));

   multi_reaction_timer #(.TIMEOUT_MS(20)) dut_b (
      .clk_i(clk), .reset_i(reset), .tick_1ms_i(tk), .arm_i(arm), .start_i(start), .stop_i(stop),
      .time_ms_o(t_b), .done_o(d_b), .false_start_o(fs_b), .timeout_o(to_b), .winner_o(w_b),
      .winner_valid_o(wv_b), .best_ms_o(b_b), .best_valid_o(bv_b), .busy_o(busy_b));

   task automatic step(input logic a, input logic s, input logic [1:0] st, input logic t);
      arm = a; start = s; stop = st; tk = t;
      @(posedge clk);
      #1;
      arm = 0; start = 0; stop = '0; tk = 0;
   endtask

   task automatic ticks(input int n);
      repeat (n) step(0, 0, 2'b00, 1);
   endtask

   task automatic do_reset();
      reset = 1;
      #2;
      reset = 0;
   endtask

   task automatic model_reset();
      m_phase = 0; m_t[0] = 0; m_t[1] = 0; m_done = 0; m_fs = 0; m_to = 0;
      m_w = 0; m_wv = 0; m_best = 0; m_bv = 0; m_busy = 0;
   endtask

   // phases: 0 idle, 1 armed, 2 running, 3 finished; timeout cap of dut_b is 20
   task automatic model_step(input logic a, input logic s, input logic [1:0] st, input logic t);
      int first;
      first = -1;
      if (a) begin
         m_phase = 1; m_t[0] = 0; m_t[1] = 0; m_done = 0; m_fs = 0; m_to = 0; m_w = 0; m_wv = 0;
      end else if (m_phase == 1) begin
         for (int i = 0; i < 2; i++)
            if (st[i] && !m_done[i]) begin m_fs[i] = 1; m_done[i] = 1; end
         if (m_done == 2'b11) m_phase = 3;
         else if (s) m_phase = 2;
      end else if (m_phase == 2) begin
         for (int i = 0; i < 2; i++)
            if (!m_done[i]) begin
               if (st[i]) begin
                  m_done[i] = 1;
                  if (first < 0) first = i;
               end else if (t) begin
                  if (m_t[i] == 20) begin m_to[i] = 1; m_done[i] = 1; end
                  else m_t[i] = m_t[i] + 1;
               end
            end
         if (!m_wv && first >= 0) begin
            m_w = 3'(first); m_wv = 1;
            if (!m_bv || m_t[first] < m_best) begin m_best = m_t[first]; m_bv = 1; end
         end
         if (m_done == 2'b11) m_phase = 3;
      end
      m_busy = (m_phase == 1) || (m_phase == 2);
   endtask

   task automatic test_reset();
      #1 reset = 1;
      #2;
      total++;
      if ({t_a, d_a, fs_a, to_a, w_a, wv_a, b_a, bv_a, busy_a} !== '0) begin
         bad++; $display("FAIL reset_a got %h want 0", {t_a, d_a, fs_a, to_a, w_a, wv_a, b_a, bv_a, busy_a});
      end
      total++;
      if ({t_b, d_b, fs_b, to_b, w_b, wv_b, b_b, bv_b, busy_b} !== '0) begin
         bad++; $display("FAIL reset_b got %h want 0", {t_b, d_b, fs_b, to_b, w_b, wv_b, b_b, bv_b, busy_b});
      end
      reset = 0;
   endtask

   task automatic test_basic();
      step(1, 0, 2'b00, 0);
      step(0, 1, 2'b00, 0);
      ticks(250);
      step(0, 0, 2'b10, 0);
      total++;
      if ({w_a, wv_a, b_a, bv_a, busy_a} !== {3'd1, 1'b1, 16'd250, 1'b1, 1'b1}) begin
         bad++; $display("FAIL basic_winner got w=%0d v=%0d best=%0d busy=%0d want 1 1 250 1", w_a, wv_a, b_a, busy_a);
      end
      ticks(30);
      step(0, 0, 2'b01, 0);
      total++;
      if (t_a !== {16'd250, 16'd280}) begin
         bad++; $display("FAIL basic_times got %0d,%0d want 250,280", t_a[31:16], t_a[15:0]);
      end
      total++;
      if ({d_a, busy_a, w_a, b_a} !== {2'b11, 1'b0, 3'd1, 16'd250}) begin
         bad++; $display("FAIL basic_finish got done=%b busy=%0d w=%0d best=%0d want 11 0 1 250", d_a, busy_a, w_a, b_a);
      end
   endtask

   task automatic test_false_start();
      step(1, 0, 2'b00, 0);
      step(0, 0, 2'b01, 0);
      total++;
      if ({fs_a, d_a, busy_a, wv_a} !== {2'b01, 2'b01, 1'b1, 1'b0}) begin
         bad++; $display("FAIL fs_early got fs=%b done=%b busy=%0d wv=%0d want 01 01 1 0", fs_a, d_a, busy_a, wv_a);
      end
      step(0, 1, 2'b00, 0);
      ticks(120);
      step(0, 0, 2'b10, 0);
      total++;
      if ({fs_a, t_a, w_a, wv_a, busy_a} !== {2'b01, 16'd120, 16'd0, 3'd1, 1'b1, 1'b0}) begin
         bad++; $display("FAIL fs_final got fs=%b t=%0d,%0d w=%0d v=%0d busy=%0d want 01 120,0 1 1 0",
                         fs_a, t_a[31:16], t_a[15:0], w_a, wv_a, busy_a);
      end
   endtask

   task automatic test_timeout();
      step(1, 0, 2'b00, 0);
      step(0, 1, 2'b00, 0);
      ticks(20);
      total++;
      if ({t_b, to_b, busy_b} !== {16'd20, 16'd20, 2'b00, 1'b1}) begin
         bad++; $display("FAIL to_cap got t=%0d,%0d to=%b busy=%0d want 20,20 00 1", t_b[31:16], t_b[15:0], to_b, busy_b);
      end
      ticks(1);
      total++;
      if ({to_b, d_b, busy_b} !== {2'b11, 2'b11, 1'b0}) begin
         bad++; $display("FAIL to_hit got to=%b done=%b busy=%0d want 11 11 0", to_b, d_b, busy_b);
      end
      ticks(19);
      total++;
      if ({t_b, wv_b} !== {16'd20, 16'd20, 1'b0}) begin
         bad++; $display("FAIL to_hold got t=%0d,%0d wv=%0d want 20,20 0", t_b[31:16], t_b[15:0], wv_b);
      end
   endtask

   task automatic test_tie();
      step(1, 0, 2'b00, 0);
      step(0, 1, 2'b00, 0);
      ticks(77);
      step(0, 0, 2'b11, 1);
      total++;
      if ({t_a, w_a, wv_a, busy_a} !== {16'd77, 16'd77, 3'd0, 1'b1, 1'b0}) begin
         bad++; $display("FAIL tie got t=%0d,%0d w=%0d v=%0d busy=%0d want 77,77 0 1 0",
                         t_a[31:16], t_a[15:0], w_a, wv_a, busy_a);
      end
   endtask

   task automatic test_best();
      int tv [3] = '{300, 180, 220};
      logic [15:0] exp_best;
      do_reset();
      exp_best = 0;
      for (int k = 0; k < 3; k++) begin
         step(1, 0, 2'b00, 0);
         step(0, 1, 2'b00, 0);
         ticks(tv[k]);
         step(0, 0, 2'b01, 0);
         if (k == 0 || 16'(tv[k]) < exp_best) exp_best = 16'(tv[k]);
         total++;
         if ({b_a, bv_a} !== {exp_best, 1'b1}) begin
            bad++; $display("FAIL best_round%0d got %0d/%0d want %0d/1", k, b_a, bv_a, exp_best);
         end
         ticks(5);
         step(0, 0, 2'b10, 0);
      end
      step(1, 0, 2'b00, 0);
      step(0, 1, 2'b00, 0);
      ticks(5);
      reset = 1;
      #1;
      total++;
      if ({t_a, d_a, fs_a, to_a, w_a, wv_a, b_a, bv_a, busy_a} !== '0) begin
         bad++; $display("FAIL best_midreset got %h want 0", {t_a, d_a, fs_a, to_a, w_a, wv_a, b_a, bv_a, busy_a});
      end
      reset = 0;
   endtask

   task automatic test_priority();
      do_reset();
      step(1, 1, 2'b00, 0);
      ticks(5);
      step(0, 0, 2'b01, 0);
      total++;
      if ({t_a, fs_a, wv_a, busy_a} !== {32'd0, 2'b01, 1'b0, 1'b1}) begin
         bad++; $display("FAIL prio_arm_start got t=%h fs=%b wv=%0d busy=%0d want 0 01 0 1", t_a, fs_a, wv_a, busy_a);
      end
      do_reset();
      step(0, 1, 2'b00, 0);
      ticks(3);
      total++;
      if ({t_a, busy_a, d_a} !== {32'd0, 1'b0, 2'b00}) begin
         bad++; $display("FAIL prio_idle_start got t=%h busy=%0d done=%b want 0 0 00", t_a, busy_a, d_a);
      end
      step(1, 0, 2'b00, 0);
      step(0, 1, 2'b00, 0);
      ticks(10);
      step(0, 0, 2'b01, 0);
      ticks(5);
      step(0, 0, 2'b01, 1);
      total++;
      if ({t_a, d_a, w_a, b_a} !== {16'd16, 16'd10, 2'b01, 3'd0, 16'd10}) begin
         bad++; $display("FAIL prio_restop got t=%0d,%0d done=%b w=%0d best=%0d want 16,10 01 0 10",
                         t_a[31:16], t_a[15:0], d_a, w_a, b_a);
      end
      step(0, 0, 2'b10, 0);
      step(0, 1, 2'b11, 1);
      total++;
      if ({t_a, d_a, busy_a, w_a} !== {16'd16, 16'd10, 2'b11, 1'b0, 3'd0}) begin
         bad++; $display("FAIL prio_finished got t=%0d,%0d done=%b busy=%0d w=%0d want 16,10 11 0 0",
                         t_a[31:16], t_a[15:0], d_a, busy_a, w_a);
      end
   endtask

   task automatic test_random();
      logic a, s, t;
      logic [1:0] st;
      logic [56:0] exp_v, got_v;
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         a = ($urandom_range(0, 99) < 3);
         s = ($urandom_range(0, 99) < 10);
         st[0] = ($urandom_range(0, 99) < 6);
         st[1] = ($urandom_range(0, 99) < 6);
         t = ($urandom_range(0, 1) == 1);
         step(a, s, st, t);
         model_step(a, s, st, t);
         exp_v = {m_t[1], m_t[0], m_done, m_fs, m_to, m_w, m_wv, m_best, m_bv, m_busy};
         got_v = {t_b, d_b, fs_b, to_b, w_b, wv_b, b_b, bv_b, busy_b};
         total++;
         if (got_v !== exp_v) begin
            bad++; $display("FAIL random cycle %0d got %h want %h", c, got_v, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_false_start();
      test_timeout();
      test_tie();
      test_best();
      test_priority();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/multi_reaction_timer.md
Name: multi_reaction_timer

Overview:
- N-channel successor of the single-player reaction timer for multi-player rounds.
- Measures each player's reaction time in ms from a shared start (LED on) to that player's stop.
- Detects false starts (stop before LED) and timeouts, picks the round winner, and keeps the best valid time since reset.
- Sits between the round-control FSM (drives arm/start) and the display/score logic; stop inputs come from debounced one-pulse button logic.

Parameters:
- N_CH, 2, number of player channels (1..8)
- TIME_W, 16, width of each time counter in bits
- TIMEOUT_MS, 9999, time cap in ms; must be <= 2^TIME_W-1
- IDX_W, 3, width of winner index; must satisfy 2^IDX_W >= N_CH

Ports:
- clk  in  1  100MHz system clock
- reset  in  1  asynchronous, active-high; clears all state
- tick_1ms  in  1  single-cycle 1ms pulse
- arm  in  1  pulse: begin a new round (pre-LED window)
- start  in  1  pulse: LED on, counting begins
- stop  in  N_CH  per-channel single-cycle button pulses
- time_ms  out  N_CH*TIME_W  channel i at bits [i*TIME_W +: TIME_W]
- done  out  N_CH  channel finished (stopped, false start or timeout)
- false_start  out  N_CH  channel pressed before start
- timeout  out  N_CH  channel hit TIMEOUT_MS
- winner  out  IDX_W  index of the fastest valid channel
- winner_valid  out  1  winner holds a valid result
- best_ms  out  TIME_W  best valid reaction time since reset
- best_valid  out  1  best_ms holds a valid value
- busy  out  1  high in ARMED or RUNNING

Behaviour:
- Reset (async): state=IDLE; all outputs 0.
- All registers update on posedge clk. Outputs are registered and reflect an event on the cycle after it.
- States are IDLE, ARMED, RUNNING, FINISHED.
- IDLE/FINISHED:
  - arm -> ARMED.
  - On entering ARMED, clear time_ms, done, false_start, timeout, winner and winner_valid. best_ms and best_valid are kept.
  - start and stop are ignored.
- ARMED:
  - stop[i] with done[i]=0 sets false_start[i]=1 and done[i]=1; time_ms[i] stays 0.
  - start -> RUNNING.
  - If all done bits become 1 (all players false-started) -> FINISHED, winner_valid=0.
  - arm while ARMED re-clears the round and stays in ARMED.
- RUNNING:
  - For each channel with done[i]=0, tick_1ms increments time_ms[i].
  - stop[i] with done[i]=0 sets done[i]=1 and freezes time_ms[i] at its current value.
  - stop and tick in the same cycle: stop wins and there is no increment.
  - If tick arrives while time_ms[i]==TIMEOUT_MS, set timeout[i]=1 and done[i]=1; time_ms[i] holds TIMEOUT_MS. The counter never wraps.
  - stop, start and repeated stop on a done channel are ignored.
  - arm in RUNNING aborts the round: the cleared ARMED round is entered and the same clears apply.
- Winner:
  - The first RUNNING cycle with any valid stop latches winner = lowest index among the channels stopping that cycle, and sets winner_valid=1.
  - Later stops never change the winner.
  - False-start and timeout channels are never winners.
- Best time:
  - When the winner latches, compare its time_ms (the frozen value) with best_ms.
  - If best_valid=0 or the winner's time is strictly less than best_ms, load best_ms and set best_valid=1.
- Leaving RUNNING:
  - When all done bits are 1 (including the stop that completes them) -> FINISHED on the next cycle.
  - busy falls in that same cycle.
- Simultaneous events:
  - arm has priority over start.
  - In ARMED, a stop[i] in the same cycle as start counts as a false start.
- Reset mid-round: immediate async clear to IDLE; best_ms is lost.

Test Plan:
- Basic round, N_CH=2:
  - Stimulus: arm, start, 250 ticks, stop[1], 30 more ticks, stop[0].
  - Required: time_ms = {250, 280} as {ch1, ch0}; winner=1, winner_valid=1, best_ms=250; busy falls after stop[0]; state FINISHED.
- False start:
  - Stimulus: arm, stop[0] before start, start, 120 ticks, stop[1].
  - Required: false_start=2'b01, time_ms[0]=0, winner=1, time_ms[1]=120.
- Timeout with TIMEOUT_MS=20:
  - Stimulus: arm, start, 40 ticks with no stops.
  - Required: timeout=2'b11, both times=20 (no wrap), winner_valid=0, FINISHED.
- Tie:
  - Stimulus: stop[0] and stop[1] in the same cycle after 77 ticks, with a tick in that same cycle.
  - Required: both times=77, winner=0.
- Best tracking over three rounds:
  - Stimulus: winning times 300, 180, 220.
  - Required: best_ms = 300, then 180, then stays 180; best_valid=1.
  - Then assert reset mid-RUNNING: all outputs 0 immediately, best_valid=0.
- Priorities and illegal stimulus:
  - Stimulus: arm and start asserted together in IDLE.
  - Required: ARMED, not RUNNING.
  - Stimulus: start in IDLE, and stop on an already-done channel.
  - Required: no effect; time_ms unchanged.
